// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle driven by vga_timing_gen and consumed by the renderers.
// frame_cnt is present only when VGA_TIMING_FRAME_CNT_EN is defined.
interface vga_timing_gen_if #(
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0] haddr;
    logic [ADDR_W-1:0] vaddr;
    logic              hsync;
    logic              vsync;
    logic              display_on;
    logic              pix_tick;
    logic              line_start;
    logic              frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0]       frame_cnt;
`endif

    modport master (
        output haddr, vaddr, hsync, vsync, display_on,
        output pix_tick, line_start, frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
        , output frame_cnt
`endif
    );

    modport slave (
        input haddr, vaddr, hsync, vsync, display_on,
        input pix_tick, line_start, frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
        , input frame_cnt
`endif
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with clock divider and run/pause.
// Optional 16-bit frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int H_SYNC_POL = 0,
    parameter int V_SYNC_POL = 0,
    parameter int CLK_DIV    = 1,
    parameter int ADDR_W     = 10
) (
    input  logic                   i_clk,
    input  logic                   i_sys_rst,
    input  logic                   i_en,
    vga_timing_gen_if.master       o_vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [ADDR_W-1:0] H_LAST   = ADDR_W'(H_TOTAL - 1);
    localparam logic [ADDR_W-1:0] V_LAST   = ADDR_W'(V_TOTAL - 1);
    localparam logic [ADDR_W-1:0] H_VIS    = ADDR_W'(H_ACTIVE);
    localparam logic [ADDR_W-1:0] V_VIS    = ADDR_W'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] HS_START = ADDR_W'(H_ACTIVE + H_FRONT);
    localparam logic [ADDR_W-1:0] HS_END   = ADDR_W'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [ADDR_W-1:0] VS_START = ADDR_W'(V_ACTIVE + V_FRONT);
    localparam logic [ADDR_W-1:0] VS_END   = ADDR_W'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic              H_POL    = 1'(H_SYNC_POL);
    localparam logic              V_POL    = 1'(V_SYNC_POL);

    logic [DIV_W-1:0]  r_div_cnt;
    logic [ADDR_W-1:0] r_haddr;
    logic [ADDR_W-1:0] r_vaddr;
    logic              r_hsync;
    logic              r_vsync;
    logic              r_display_on;
    logic              r_line_start;
    logic              r_frame_start;

    logic              w_tick;
    logic              w_h_wrap;
    logic              w_v_wrap;
    logic [DIV_W-1:0]  w_div_nxt;
    logic [ADDR_W-1:0] w_haddr_nxt;
    logic [ADDR_W-1:0] w_vaddr_nxt;
    logic              w_hsync_nxt;
    logic              w_vsync_nxt;
    logic              w_display_nxt;

    // Next-state counters; sync/blank decode uses the next values so they align with the addresses.
    always_comb begin
        w_tick        = i_en && (r_div_cnt == DIV_LAST);
        w_h_wrap      = (r_haddr == H_LAST);
        w_v_wrap      = (r_vaddr == V_LAST);
        w_div_nxt     = r_div_cnt;
        w_haddr_nxt   = r_haddr;
        w_vaddr_nxt   = r_vaddr;
        if (!i_en) begin
            w_div_nxt = r_div_cnt;
        end else if (w_tick) begin
            w_div_nxt = '0;
        end else begin
            w_div_nxt = r_div_cnt + DIV_W'(1);
        end
        if (w_tick) begin
            w_haddr_nxt = w_h_wrap ? '0 : (r_haddr + ADDR_W'(1));
        end else begin
            w_haddr_nxt = r_haddr;
        end
        if (w_tick && w_h_wrap) begin
            w_vaddr_nxt = w_v_wrap ? '0 : (r_vaddr + ADDR_W'(1));
        end else begin
            w_vaddr_nxt = r_vaddr;
        end
        w_hsync_nxt   = ((w_haddr_nxt >= HS_START) && (w_haddr_nxt < HS_END)) ? H_POL : ~H_POL;
        w_vsync_nxt   = ((w_vaddr_nxt >= VS_START) && (w_vaddr_nxt < VS_END)) ? V_POL : ~V_POL;
        w_display_nxt = (w_haddr_nxt < H_VIS) && (w_vaddr_nxt < V_VIS);
    end

    // Timing state and registered outputs; strobes can only fire on a tick, so they drop while paused.
    always_ff @(posedge i_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            r_div_cnt     <= '0;
            r_haddr       <= '0;
            r_vaddr       <= '0;
            r_hsync       <= ~H_POL;
            r_vsync       <= ~V_POL;
            r_display_on  <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_div_cnt     <= w_div_nxt;
            r_haddr       <= w_haddr_nxt;
            r_vaddr       <= w_vaddr_nxt;
            r_hsync       <= w_hsync_nxt;
            r_vsync       <= w_vsync_nxt;
            r_display_on  <= w_display_nxt;
            r_line_start  <= w_tick && w_h_wrap;
            r_frame_start <= w_tick && w_h_wrap && w_v_wrap;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    // Frame counter advances on the same edge that raises frame_start.
    always_ff @(posedge i_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            r_frame_cnt <= 16'd0;
        end else if (w_tick && w_h_wrap && w_v_wrap) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end else begin
            r_frame_cnt <= r_frame_cnt;
        end
    end

    assign o_vga.frame_cnt = r_frame_cnt;
`endif

    assign o_vga.haddr       = r_haddr;
    assign o_vga.vaddr       = r_vaddr;
    assign o_vga.hsync       = r_hsync;
    assign o_vga.vsync       = r_vsync;
    assign o_vga.display_on  = r_display_on;
    assign o_vga.pix_tick    = w_tick;
    assign o_vga.line_start  = r_line_start;
    assign o_vga.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: two reduced-geometry instances (CLK_DIV 1 / active-low sync,
// CLK_DIV 3 / active-high sync) under random enable and reset, checked against a tick-count model.
module tb_vga_timing_gen;

    localparam int HA = 16, HF = 2, HS = 3, HB = 4;
    localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int NCYC  = 8000;
    localparam int DIVS [2] = '{1, 3};
    localparam int POLS [2] = '{0, 1};

    typedef struct {
        int haddr;
        int vaddr;
        int hsync;
        int vsync;
        int de;
        int pt;
        int ls;
        int fs;
        int fc;
    } exp_t;

    logic clk = 1'b0;
    logic sys_rst = 1'b0;
    logic en = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    exp_t q0[$];
    exp_t q1[$];

    vga_timing_gen_if #(.ADDR_W(10)) vif0 ();
    vga_timing_gen_if #(.ADDR_W(6))  vif1 ();

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_SYNC_POL(0), .V_SYNC_POL(0), .CLK_DIV(1), .ADDR_W(10)
    ) dut0 (
        .i_clk(clk), .i_sys_rst(sys_rst), .i_en(en), .o_vga(vif0)
    );

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_SYNC_POL(1), .V_SYNC_POL(1), .CLK_DIV(3), .ADDR_W(6)
    ) dut1 (
        .i_clk(clk), .i_sys_rst(sys_rst), .i_en(en), .o_vga(vif1)
    );

    always #5 clk = ~clk;

    // Reference: everything follows from the number of enabled cycles since reset.
    function automatic exp_t model(int k, longint cyc, bit ticked, bit en_now);
        exp_t   e;
        longint ticks, pos;
        int     d, pol;
        d     = DIVS[k];
        pol   = POLS[k];
        ticks = cyc / d;
        pos   = ticks % FRAME;
        e.haddr = int'(pos % HT);
        e.vaddr = int'(pos / HT);
        e.hsync = (e.haddr >= HA + HF && e.haddr < HA + HF + HS) ? pol : 1 - pol;
        e.vsync = (e.vaddr >= VA + VF && e.vaddr < VA + VF + VS) ? pol : 1 - pol;
        e.de    = (e.haddr < HA && e.vaddr < VA) ? 1 : 0;
        e.pt    = (en_now && (cyc % d == longint'(d - 1))) ? 1 : 0;
        e.ls    = (ticked && e.haddr == 0) ? 1 : 0;
        e.fs    = (ticked && pos == 0) ? 1 : 0;
        e.fc    = int'((ticks / FRAME) % 65536);
        return e;
    endfunction

    task automatic cmp(int k, string name, int act, int exp_v);
        if (act != exp_v) begin
            n_err++;
            $display("FAIL dut%0d %s at %0t: got %0d, expected %0d", k, name, $time, act, exp_v);
        end
    endtask

    task automatic check(int k, exp_t e, exp_t a);
        n_vec++;
        cmp(k, "haddr",       a.haddr, e.haddr);
        cmp(k, "vaddr",       a.vaddr, e.vaddr);
        cmp(k, "hsync",       a.hsync, e.hsync);
        cmp(k, "vsync",       a.vsync, e.vsync);
        cmp(k, "display_on",  a.de,    e.de);
        cmp(k, "pix_tick",    a.pt,    e.pt);
        cmp(k, "line_start",  a.ls,    e.ls);
        cmp(k, "frame_start", a.fs,    e.fs);
`ifdef VGA_TIMING_FRAME_CNT_EN
        cmp(k, "frame_cnt",   a.fc,    e.fc);
`endif
    endtask

    // Monitor for instance 0.
    initial begin
        exp_t e, a;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                a.haddr = int'(vif0.haddr);
                a.vaddr = int'(vif0.vaddr);
                a.hsync = int'(vif0.hsync);
                a.vsync = int'(vif0.vsync);
                a.de    = int'(vif0.display_on);
                a.pt    = int'(vif0.pix_tick);
                a.ls    = int'(vif0.line_start);
                a.fs    = int'(vif0.frame_start);
`ifdef VGA_TIMING_FRAME_CNT_EN
                a.fc    = int'(vif0.frame_cnt);
`else
                a.fc    = 0;
`endif
                check(0, e, a);
            end
        end
    end

    // Monitor for instance 1.
    initial begin
        exp_t e, a;
        forever begin
            @(negedge clk);
            if (q1.size() > 0) begin
                e = q1.pop_front();
                a.haddr = int'(vif1.haddr);
                a.vaddr = int'(vif1.vaddr);
                a.hsync = int'(vif1.hsync);
                a.vsync = int'(vif1.vsync);
                a.de    = int'(vif1.display_on);
                a.pt    = int'(vif1.pix_tick);
                a.ls    = int'(vif1.line_start);
                a.fs    = int'(vif1.frame_start);
`ifdef VGA_TIMING_FRAME_CNT_EN
                a.fc    = int'(vif1.frame_cnt);
`else
                a.fc    = 0;
`endif
                check(1, e, a);
            end
        end
    end

    // Stimulus: random run/pause bursts and occasional mid-frame resets; expectations pushed per cycle.
    initial begin
        longint cyc [2];
        bit     ticked [2];
        bit     rst_b, en_b;
        int     waited;
        rst_b = 1'b0;
        en_b  = 1'b0;
        cyc[0] = 0;
        cyc[1] = 0;
        repeat (3) @(posedge clk);
        for (int n = 0; n < NCYC; n++) begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                ticked[k] = 1'b0;
                if (!rst_b) begin
                    cyc[k] = 0;
                end else if (en_b) begin
                    cyc[k]++;
                    ticked[k] = (cyc[k] % DIVS[k] == 0);
                end
            end
            #2;
            if (!rst_b) begin
                rst_b = 1'b1;
                if (n == 0) en_b = 1'b1;
            end else if (n == 4003 || $urandom_range(0, 2999) == 0) begin
                rst_b = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    cyc[k]    = 0;
                    ticked[k] = 1'b0;
                end
            end
            if (n > 0) begin
                if (en_b) begin
                    if ($urandom_range(0, 59) == 0) en_b = 1'b0;
                end else begin
                    if ($urandom_range(0, 9) == 0) en_b = 1'b1;
                end
            end
            sys_rst = rst_b;
            en      = en_b;
            q0.push_back(model(0, cyc[0], ticked[0], en_b));
            q1.push_back(model(1, cyc[1], ticked[1], en_b));
        end
        waited = 0;
        while ((q0.size() > 0 || q1.size() > 0) && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        if (q0.size() > 0 || q1.size() > 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, expected 0", q0.size() + q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator. It is the next generation of the fixed 640x480 vga block.
- Produces pixel/line counters, sync pulses, active-video flag, line/frame strobes and a pixel-clock tick for the game renderers.
- Generalised over all H/V timing fields, sync polarity and a system-clock-to-pixel-clock divider.
- Adds run/pause control.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- H_SYNC_POL, 0, hsync asserted level (0 = active-low, 1 = active-high)
- V_SYNC_POL, 0, vsync asserted level (0 = active-low, 1 = active-high)
- CLK_DIV, 1, system clocks per pixel (>=1)
- ADDR_W, 10, counter/address width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  in  1  system clock
- sys_rst  in  1  reset, asynchronous, active-low
- en  in  1  run enable; low freezes timing
- haddr  out  ADDR_W  current pixel column, 0..H_TOTAL-1
- vaddr  out  ADDR_W  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- display_on  out  1  high when haddr<H_ACTIVE and vaddr<V_ACTIVE
- pix_tick  out  1  one-clk strobe; the counters advance on the following edge
- line_start  out  1  one-clk pulse when haddr wraps to 0
- frame_start  out  1  one-clk pulse when haddr and vaddr both wrap to 0

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (default 800); V_TOTAL = V_ACTIVE+V_FRONT+V_SYNC+V_BACK (default 525).
- Divider: div_cnt counts 0..CLK_DIV-1 while en=1.
  - pix_tick = en && (div_cnt == CLK_DIV-1), combinational from registers.
  - With CLK_DIV=1, pix_tick = en.
- On a clock edge with pix_tick=1:
  - haddr increments.
  - At H_TOTAL-1, haddr wraps to 0 and vaddr increments.
  - vaddr at V_TOTAL-1 wraps to 0 on the same edge as the haddr wrap.
- hsync, vsync and display_on are registered. They are computed from the next counter values, so they change on the same edge as haddr/vaddr (zero skew).
  - hsync asserted iff H_ACTIVE+H_FRONT <= haddr < H_ACTIVE+H_FRONT+H_SYNC.
  - vsync asserted iff V_ACTIVE+V_FRONT <= vaddr < V_ACTIVE+V_FRONT+V_SYNC.
  - Asserted level = *_SYNC_POL; deasserted level = its inverse.
- line_start and frame_start are registered pulses. Each is high for exactly one clk, starting on the edge where the wrap occurs. Every frame_start coincides with a line_start.
- en=0:
  - div_cnt, counters and all registered outputs hold.
  - pix_tick=0.
  - line_start and frame_start are forced to 0 on the next edge.
  - Resuming continues from the held div_cnt value without a phase reset.
- Reset (async assert, sync deassert handled upstream), all values:
  - div_cnt=0, haddr=0, vaddr=0
  - hsync=~H_SYNC_POL, vsync=~V_SYNC_POL
  - display_on=1
  - line_start=0, frame_start=0
- Reset mid-frame returns to the values above immediately. No frame_start is emitted for the first frame after reset.
- Counter arithmetic is unsigned ADDR_W, and compares use full width. Illegal parameters (zero field, CLK_DIV=0, totals overflowing ADDR_W) are out of scope.

Optional Feature:
- Macro: VGA_TIMING_FRAME_CNT_EN.
- When defined:
  - Extra output frame_cnt (out, 16 bits).
  - Reset value 0.
  - Increments on the edge where frame_start is driven high.
  - Wraps 0xFFFF -> 0x0000.
  - Holds while en=0.
  - Used by the game for animation and scroll timing.
- When undefined: the port and its register are absent. All other behaviour is identical.

Test Plan:
- Defaults, CLK_DIV=1, en=1 from reset release (edge 1 = first edge):
  - haddr = N mod 800 at edge N.
  - hsync falls to 0 at edge 656 and returns to 1 at edge 752.
  - display_on falls at edge 640.
  - line_start is high for exactly edge 800's cycle, when haddr=0 and vaddr=1.
- Defaults, run a full frame:
  - vsync is 0 exactly for vaddr 490..491 (edges 392000..393599).
  - frame_start pulses once at edge 420000 with haddr=vaddr=0.
  - No pulse at edge 0.
- CLK_DIV=4:
  - pix_tick high on edges 4,8,12,...
  - haddr=1 after edge 4, haddr=2 after edge 8.
  - line_start at edge 3200.
- Pause:
  - Drop en at haddr=100, hold 50 clks -> all outputs frozen, pix_tick=0, no strobes.
  - Re-raise en -> haddr=101 on the next tick.
- H_SYNC_POL=1, V_SYNC_POL=1:
  - Reset values hsync=0, vsync=0.
  - hsync=1 for haddr 656..751.
- Reset mid-frame at vaddr=300:
  - Outputs return to reset values asynchronously.
  - Next frame_start arrives 420000 edges after release.
  - With VGA_TIMING_FRAME_CNT_EN, frame_cnt=0 after reset and 1 after that frame_start.
